// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line levels of the frame delimiters.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  localparam logic StartBit = 1'b0;
  localparam logic StopBit  = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to all ones so an idle-high line stays quiet.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two-stage metastability filter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing (DATA_W data bits, no parity) with a
// valid/ready output holding register, frame error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW = $clog2(DATA_W);
  localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

  logic              rx_sync;
  logic              rx_prev_q, rx_prev_d;
  uart_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  // After reset the synchronizer holds ones that never came from the line; a
  // frame may only start once the real line has been seen high.
  logic [1:0]        flush_q, flush_d;
  logic              armed_q, armed_d;
  logic              line_fall;

  sync_2ff #(
    .Width (1)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (rx),
    .q_o    (rx_sync)
  );

  assign line_fall = armed_q & rx_prev_q & ~rx_sync;

  // Next-state logic for the receive FSM, counters and output register
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    rx_prev_d   = rx_sync;
    flush_d     = (flush_q == 2'd3) ? flush_q : flush_q + 2'd1;
    armed_d     = armed_q | ((flush_q == 2'd3) & rx_sync);

    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (line_fall) begin
          state_d   = StStart;
          bit_cnt_d = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfEnd) begin
          cnt_d   = '0;
          state_d = (rx_sync == StartBit) ? StData : StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitEnd) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[DATA_W-1:1]};
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            state_d   = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == BitEnd) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rx_sync == StopBit) begin
            // A word consumed this same cycle frees the register for the new one
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_prev_q   <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit, 8 data bits.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int Cpb    = 16;
  localparam int LatMin = 9 * Cpb + Cpb / 2 + 2;
  localparam int LatMax = 9 * Cpb + Cpb / 2 + 4;
  // Delivery edge of this implementation, used to time ready for the same-cycle case
  localparam int LatRtl = 9 * Cpb + Cpb / 2 + 3;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  int n_vec;
  int n_err;
  int cyc;
  int fall_cyc;
  int rise_cyc;
  int rise_cnt;
  int vfall_cnt;
  int fe_cnt;
  int ov_cnt;
  int both_cnt;
  logic valid_prev;

  int b_rise, b_vfall, b_fe, b_ov;

  uart_rx #(
    .CLKS_PER_BIT (Cpb),
    .DATA_W       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge
  initial begin
    rise_cnt = 0; vfall_cnt = 0; fe_cnt = 0; ov_cnt = 0; both_cnt = 0;
    rise_cyc = 0; valid_prev = 1'b0;
  end
  always @(negedge clk) begin
    if (valid && !valid_prev) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (!valid && valid_prev) vfall_cnt <= vfall_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
    if (frame_err && overrun) both_cnt <= both_cnt + 1;
    valid_prev <= valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_rise = rise_cnt; b_vfall = vfall_cnt; b_fe = fe_cnt; b_ov = ov_cnt;
  endtask

  // Drives one frame; leaves rx at the stop level when done
  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    @(posedge clk);
    #1;
    rx = 1'b0;
    fall_cyc = cyc;
    hold(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(Cpb);
    end
    rx = stop_v;
    hold(Cpb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    fall_cyc = 0;
    rst = 1'b0;
    rx = 1'b1;
    ready = 1'b1;
    hold(3);
    check_eq("rst_data", 32'(data), 32'h0);
    check_eq("rst_valid", 32'(valid), 32'h0);
    check_eq("rst_ferr", 32'(frame_err), 32'h0);
    check_eq("rst_ovr", 32'(overrun), 32'h0);
    rst = 1'b1;
    hold(10);

    // Clean byte with ready held high
    snap();
    send_frame(8'hA5, 1'b1);
    rx = 1'b1;
    hold(20);
    check_eq("a5_rises", 32'(rise_cnt - b_rise), 32'd1);
    check_eq("a5_one_cycle", 32'(vfall_cnt - b_vfall), 32'd1);
    check_eq("a5_data", 32'(data), 32'hA5);
    check_eq("a5_lat_in_154_156", 32'(((rise_cyc - fall_cyc) >= LatMin) &&
                                      ((rise_cyc - fall_cyc) <= LatMax)), 32'd1);
    check_eq("a5_no_err", 32'(fe_cnt - b_fe + ov_cnt - b_ov), 32'd0);

    // Short low glitch is rejected
    snap();
    rx = 1'b0;
    hold(6);
    rx = 1'b1;
    hold(60);
    check_eq("glitch_idle", 32'(dut.state_q), 32'(StIdle));
    check_eq("glitch_no_valid", 32'(rise_cnt - b_rise), 32'd0);
    check_eq("glitch_no_ferr", 32'(fe_cnt - b_fe), 32'd0);
    check_eq("glitch_no_ovr", 32'(ov_cnt - b_ov), 32'd0);

    // Bad stop bit followed by a long break
    snap();
    send_frame(8'h3C, 1'b0);
    hold(200);
    rx = 1'b1;
    hold(40);
    check_eq("break_one_ferr", 32'(fe_cnt - b_fe), 32'd1);
    check_eq("break_data", 32'(data), 32'hA5);
    check_eq("break_valid", 32'(valid), 32'h0);
    check_eq("break_no_rise", 32'(rise_cnt - b_rise), 32'd0);
    check_eq("break_no_ovr", 32'(ov_cnt - b_ov), 32'd0);

    // Overrun with the consumer stalled
    ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1);
    rx = 1'b1;
    hold(4);
    send_frame(8'h22, 1'b1);
    rx = 1'b1;
    hold(20);
    check_eq("ovr_data", 32'(data), 32'h11);
    check_eq("ovr_valid", 32'(valid), 32'h1);
    check_eq("ovr_pulses", 32'(ov_cnt - b_ov), 32'd1);
    check_eq("ovr_no_ferr", 32'(fe_cnt - b_fe), 32'd0);
    ready = 1'b1;
    hold(1);
    ready = 1'b0;
    check_eq("ovr_drain_valid", 32'(valid), 32'h0);

    // New word arriving on the same cycle the old one is consumed
    snap();
    send_frame(8'h55, 1'b1);
    rx = 1'b1;
    hold(4);
    check_eq("same_first", 32'(data), 32'h55);
    snap();
    fork
      send_frame(8'h66, 1'b1);
      begin
        repeat (LatRtl) @(posedge clk);
        #1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
      end
    join
    rx = 1'b1;
    hold(10);
    check_eq("same_data", 32'(data), 32'h66);
    check_eq("same_valid", 32'(valid), 32'h1);
    check_eq("same_no_drop", 32'(vfall_cnt - b_vfall), 32'd0);
    check_eq("same_no_ovr", 32'(ov_cnt - b_ov), 32'd0);
    ready = 1'b1;
    hold(2);

    // Reset during a low data bit, line still low after release
    snap();
    @(posedge clk);
    #1;
    rx = 1'b0;
    hold(Cpb + 3 * Cpb + Cpb / 2);
    rst = 1'b0;
    hold(2);
    check_eq("mid_rst_data", 32'(data), 32'h0);
    check_eq("mid_rst_valid", 32'(valid), 32'h0);
    check_eq("mid_rst_ferr", 32'(frame_err), 32'h0);
    check_eq("mid_rst_ovr", 32'(overrun), 32'h0);
    hold(3);
    rst = 1'b1;
    hold(40);
    rx = 1'b1;
    hold(200);
    check_eq("post_rst_no_rise", 32'(rise_cnt - b_rise), 32'd0);
    check_eq("post_rst_no_err", 32'(fe_cnt - b_fe + ov_cnt - b_ov), 32'd0);
    check_eq("post_rst_data", 32'(data), 32'h0);
    snap();
    send_frame(8'h81, 1'b1);
    rx = 1'b1;
    hold(20);
    check_eq("post_rst_81", 32'(data), 32'h81);
    check_eq("post_rst_81_rise", 32'(rise_cnt - b_rise), 32'd1);

    check_eq("ferr_ovr_exclusive", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter CLKS_PER_BIT SHALL default to 868 (clk cycles per bit), legal range 4..65535.
REQ-003 Parameter DATA_W SHALL default to 8 (data bits per frame), legal range 5..9.
REQ-004 Port clk  input  1  rising-edge system clock.
REQ-005 Port rst  input  1  asynchronous active-low reset.
REQ-006 Port rx  input  1  asynchronous serial line, idle high.
REQ-007 Port data  output  DATA_W  last good received word.
REQ-008 Port valid  output  1  data holds an unconsumed word.
REQ-009 Port ready  input  1  consumer accepts data when valid && ready.
REQ-010 Port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-011 Port overrun  output  1  one-cycle pulse, completed word dropped.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer, then a 1-flop edge register; only the synchronized value is used.
REQ-013 Frame format SHALL be 1 start bit (0), DATA_W data bits LSB first, 1 stop bit (1), no parity.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE -> START on a synchronized 1->0 transition; the bit counter clears to 0.
REQ-016 START: after CLKS_PER_BIT/2 (integer division) cycles, sample rx; 0 -> DATA, 1 -> IDLE (glitch rejected, no output).
REQ-017 DATA: sample every CLKS_PER_BIT cycles and shift the sample into bit DATA_W-1 of a right-shift register; after DATA_W samples -> STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles, sample rx; 1 -> deliver the word, 0 -> pulse frame_err, discard the word; both -> IDLE.
REQ-019 After frame_err, a new frame SHALL start only on a fresh 1->0 edge, so a held-low (break) line produces exactly one frame_err.
REQ-020 Baud counter width SHALL be the minimum width holding CLKS_PER_BIT-1; it reloads to 0 on each sample.
REQ-021 Delivery: data loads and valid sets on the cycle after the stop sample; total latency from rx falling to valid rising SHALL lie in [9*CLKS_PER_BIT + CLKS_PER_BIT/2 + 2, + 4] for DATA_W=8.
REQ-022 valid SHALL stay 1 and data stable until a cycle with valid && ready; valid then clears the next cycle.
REQ-023 Delivery while valid && !ready SHALL keep the old data, drop the new word, and pulse overrun.
REQ-024 Delivery in the same cycle as valid && ready SHALL load the new word, keep valid at 1, and not pulse overrun.
REQ-025 Reception SHALL continue independently of ready; the FSM never stalls.
REQ-026 frame_err and overrun SHALL never assert in the same cycle.

Reset
REQ-027 On rst low: FSM = IDLE, counters = 0, shift register = 0, data = 0, valid = 0, frame_err = 0, overrun = 0, synchronizer and edge flops = 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no output; after release, a line still low SHALL NOT start a frame until it returns high and falls again.
REQ-029 Reset deassertion SHALL take effect on the next rising clk edge; no output changes before it.

Structure
REQ-030 The FSM state encoding and the frame constants (start/stop levels) SHALL live in a shared package uart_pkg, reused by a future uart_tx.
REQ-031 The 2-flop synchronizer SHALL be one sub-module, sync_2ff (width parameter, reset value 1); all other logic is flat.
REQ-032 All flops SHALL use the asynchronous active-low reset; there are no latches and no clocks derived from logic.

Verification (CLKS_PER_BIT=16, DATA_W=8)
REQ-033 Send byte 0xA5 with ready=1 -> valid for exactly 1 cycle, data=0xA5, rising within 154..156 cycles of the rx fall.
REQ-034 Pulse rx low for 6 cycles -> FSM returns to IDLE; no valid, frame_err or overrun.
REQ-035 Send 0x3C with stop bit forced 0, then hold rx low 200 cycles -> exactly one frame_err pulse; data unchanged; valid=0.
REQ-036 ready=0; send 0x11 then 0x22 -> data=0x11, valid=1, one overrun pulse at the second delivery; then ready=1 for 1 cycle -> valid=0.
REQ-037 ready=0; send 0x55; time ready=1 to the delivery cycle of 0x66 -> data=0x66, valid stays 1, no overrun.
REQ-038 Assert rst during bit 4 of 0xF0 while rx is low, then release -> all outputs 0; the next clean 0x81 is received correctly.
